// File: rtl/mem_pkg.sv
// Shared defaults and FSM state encoding for the single-port memory controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int ASIZE_DEF   = 16;
    localparam int DSIZE_DEF   = 16;
    localparam int MEM_LAT_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_arb.sv
// Two-way grant selection between the instruction and data ports (option macro: MEMCTRL_RR_EN).
// Latency: combinational, grants in the same cycle as the request when enabled.
// Backpressure: no grant while en is low; requesters must hold req until granted.
module mem_arb
    import mem_pkg::*;
(
`ifdef MEMCTRL_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic en,
    input  logic if_req,
    input  logic d_req,
    output logic if_win,
    output logic d_win
);

`ifdef MEMCTRL_RR_EN
    // High when the instruction port should win the next tie; reset favours data.
    logic prio_if;

    // Pick a winner; a tie goes to the port that was not granted most recently.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (en) begin
            if (if_req && d_req) begin
                if_win = prio_if;
                d_win  = !prio_if;
            end else begin
                if_win = if_req;
                d_win  = d_req;
            end
        end
    end

    // Remember who was served last so the other side wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_if <= 1'b0;
        end else if (if_win || d_win) begin
            prio_if <= d_win;
        end
    end
`else
    // Fixed priority: the data port always wins a tie.
    always_comb begin
        if_win = 1'b0;
        d_win  = 1'b0;
        if (en) begin
            d_win  = d_req;
            if_win = if_req && !d_req;
        end
    end
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Two-port (instruction/data) front end for a fixed-latency single-port memory (option macro: MEMCTRL_RR_EN).
// Latency: grant in cycle t, mem_cs in t+1, rdata registered end of t+MEM_LAT+1, done pulse in t+MEM_LAT+2.
// Backpressure: one access in flight; requests seen while busy are not granted and must be held.
module mem_ctrl
    import mem_pkg::*;
#(
    parameter int ASIZE   = ASIZE_DEF,
    parameter int DSIZE   = DSIZE_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [ASIZE-1:0] if_addr,
    output logic             if_gnt,
    output logic [DSIZE-1:0] if_rdata,
    output logic             if_done,
    input  logic             d_req,
    input  logic             d_wen,
    input  logic [ASIZE-1:0] d_addr,
    input  logic [DSIZE-1:0] d_wdata,
    output logic             d_gnt,
    output logic [DSIZE-1:0] d_rdata,
    output logic             d_done,
    output logic             mem_cs,
    output logic             mem_wen,
    output logic [ASIZE-1:0] mem_addr,
    output logic [DSIZE-1:0] mem_data_in,
    input  logic [DSIZE-1:0] mem_data_out,
    output logic             busy
);

    // WAIT lasts MEM_LAT-1 cycles: counter reloads to MEM_LAT-2 and exits at zero.
    localparam int CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int RELOAD_I = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;
    localparam logic [CW-1:0] RELOAD = CW'(RELOAD_I);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic             sel_d;
    logic             wen_q;
    logic [ASIZE-1:0] addr_q;
    logic [DSIZE-1:0] wdata_q;
    logic             grant_en;
    logic             if_win;
    logic             d_win;
    logic             any_win;

    // Grants are only offered in IDLE and never while reset is asserted.
    assign grant_en = (state == IDLE) && !rst;
    assign any_win  = if_win || d_win;
    assign if_gnt   = if_win;
    assign d_gnt    = d_win;

    assign mem_addr    = addr_q;
    assign mem_data_in = wdata_q;

    mem_arb u_arb (
`ifdef MEMCTRL_RR_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .en     (grant_en),
        .if_req (if_req),
        .d_req  (d_req),
        .if_win (if_win),
        .d_win  (d_win)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus memory strobe and busy decode.
    always_comb begin
        state_nxt = state;
        mem_cs    = 1'b0;
        mem_wen   = 1'b1;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (any_win) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_cs  = 1'b1;
                mem_wen = wen_q;
                if (MEM_LAT > 1) begin
                    state_nxt = WAIT;
                end else begin
                    state_nxt = DONE;
                end
            end
            WAIT: begin
                mem_wen = wen_q;
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                mem_wen   = wen_q;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Wait counter: loaded only when ISSUE hands over to WAIT, then counts down.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (state == ISSUE) begin
            cnt <= RELOAD;
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture the winner's request at grant so later req/addr changes cannot disturb it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_d   <= 1'b0;
            wen_q   <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (any_win) begin
            sel_d  <= d_win;
            addr_q <= d_win ? d_addr : if_addr;
            wen_q  <= d_win ? d_wen : 1'b1;
            if (d_win) begin
                wdata_q <= d_wdata;
            end
        end
    end

    // Completion: sample read data at the end of DONE and pulse done the cycle after.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_done  <= 1'b0;
            d_done   <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
        end else begin
            if_done <= (state == DONE) && !sel_d;
            d_done  <= (state == DONE) && sel_d;
            if ((state == DONE) && wen_q) begin
                if (sel_d) begin
                    d_rdata <= mem_data_out;
                end else begin
                    if_rdata <= mem_data_out;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a behavioural fixed-latency memory and per-port scoreboards.
// Latency: expects grant t, mem_cs t+1, done t+5 for MEM_LAT=3.
// Backpressure: checks held requests are granted only once the controller returns to IDLE.
module tb_mem_ctrl;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int LAT = 3;

    logic          clk;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_wen;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_cs;
    logic          mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic          do_preload;
    logic [DW-1:0] tb_mem  [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] pipe    [LAT];
    logic [DW-1:0] exp_if [$];
    logic [DW-1:0] exp_d  [$];
    logic [DW-1:0] last_if;
    logic [DW-1:0] last_d;
    logic          favour_if;
    logic          prev_cs;

    mem_ctrl #(.ASIZE(AW), .DSIZE(DW), .MEM_LAT(LAT)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_gnt       (if_gnt),
        .if_rdata     (if_rdata),
        .if_done      (if_done),
        .d_req        (d_req),
        .d_wen        (d_wen),
        .d_addr       (d_addr),
        .d_wdata      (d_wdata),
        .d_gnt        (d_gnt),
        .d_rdata      (d_rdata),
        .d_done       (d_done),
        .mem_cs       (mem_cs),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] pat(input int i);
        return DW'((i * 32'h1357) ^ 32'hA5C3);
    endfunction

    // Behavioural memory: samples cs on an edge, read data appears LAT edges later, X otherwise.
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= pat(i);
        end else if (mem_cs && !mem_wen) begin
            tb_mem[mem_addr[7:0]] <= mem_data_in;
        end
        pipe[0] <= (mem_cs && mem_wen) ? tb_mem[mem_addr[7:0]] : 'x;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_data_out = pipe[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer plus the no-back-to-back chip select rule.
    always @(negedge clk) begin
        if (!rst) chk("cs_adjacent", 32'(mem_cs & prev_cs), 32'd0);
        prev_cs <= mem_cs;
        if (if_done) begin
            chk("if_done_expected", 32'(exp_if.size() != 0), 32'd1);
            if (exp_if.size() != 0) chk("if_rdata", 32'(if_rdata), 32'(exp_if.pop_front()));
        end
        if (d_done) begin
            chk("d_done_expected", 32'(exp_d.size() != 0), 32'd1);
            if (exp_d.size() != 0) chk("d_rdata", 32'(d_rdata), 32'(exp_d.pop_front()));
        end
    end

    // Producer: expected rdata at done; a write leaves the port's last read value.
    task automatic push_exp(input bit is_d, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        logic [DW-1:0] v;
        if (rd) begin
            v = ref_mem[a[7:0]];
            if (is_d) last_d = v; else last_if = v;
        end else begin
            ref_mem[a[7:0]] = wd;
            v = is_d ? last_d : last_if;
        end
        if (is_d) exp_d.push_back(v); else exp_if.push_back(v);
        favour_if = is_d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input bit is_d, input bit rd, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        bit got;
        next_cycle();
        if (is_d) begin
            d_req = 1'b1; d_wen = rd; d_addr = a; d_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = a;
        end
        got = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if ((is_d ? d_gnt : if_gnt) === 1'b1) begin
                got = 1'b1;
                break;
            end
            next_cycle();
        end
        chk("acc_gnt", 32'(got), 32'd1);
        push_exp(is_d, rd, a, wd);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) begin
                if (is_d) begin
                    d_req = 1'b0; d_addr = a ^ 16'h00F0; d_wdata = ~wd; d_wen = ~d_wen;
                end else begin
                    if_req = 1'b0; if_addr = a ^ 16'h00F0;
                end
            end
            @(negedge clk);
            chk("acc_mem_cs", 32'(mem_cs), 32'(k == 1));
            if (k < 5) begin
                chk("acc_mem_wen", 32'(mem_wen), 32'(rd));
                chk("acc_mem_addr", 32'(mem_addr), 32'(a));
                if (!rd) chk("acc_mem_data_in", 32'(mem_data_in), 32'(wd));
                chk("acc_busy", 32'(busy), 32'd1);
                chk("acc_done_early", 32'(is_d ? d_done : if_done), 32'd0);
            end else begin
                chk("acc_done", 32'(is_d ? d_done : if_done), 32'd1);
                chk("acc_idle_wen", 32'(mem_wen), 32'd1);
                chk("acc_idle_busy", 32'(busy), 32'd0);
            end
        end
        d_wen = 1'b1;
    endtask

    task automatic tie(input logic [AW-1:0] a_if, input logic [AW-1:0] a_d);
        bit w_d;
        next_cycle();
        if_req = 1'b1; if_addr = a_if;
        d_req = 1'b1; d_wen = 1'b1; d_addr = a_d;
        @(negedge clk);
`ifdef MEMCTRL_RR_EN
        w_d = !favour_if;
`else
        w_d = 1'b1;
`endif
        chk("tie_d_gnt", 32'(d_gnt), 32'(w_d));
        chk("tie_if_gnt", 32'(if_gnt), 32'(!w_d));
        push_exp(w_d, 1'b1, w_d ? a_d : a_if, '0);
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) begin
                if (w_d) d_req = 1'b0; else if_req = 1'b0;
            end
            @(negedge clk);
            if (k < 5) begin
                chk("tie_loser_wait", 32'(w_d ? if_gnt : d_gnt), 32'd0);
            end else begin
                chk("tie_loser_gnt", 32'(w_d ? if_gnt : d_gnt), 32'd1);
                chk("tie_winner_done", 32'(w_d ? d_done : if_done), 32'd1);
                push_exp(!w_d, 1'b1, w_d ? a_if : a_d, '0);
            end
        end
        for (int k = 1; k <= 5; k++) begin
            next_cycle();
            if (k == 1) begin
                if_req = 1'b0; d_req = 1'b0;
            end
            @(negedge clk);
            if (k == 5) chk("tie_loser_done", 32'(w_d ? if_done : d_done), 32'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "bench did not complete");
    end

    initial begin
        int last_g;
        bit got;
        rst = 1'b1; do_preload = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_wen = 1'b1; d_addr = '0; d_wdata = '0;
        last_if = '0; last_d = '0; favour_if = 1'b0; prev_cs = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);

        // Reset held for two cycles.
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("rst_mem_cs", 32'(mem_cs), 32'd0);
        chk("rst_mem_wen", 32'(mem_wen), 32'd1);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_data_in", 32'(mem_data_in), 32'd0);
        chk("rst_gnts", 32'({if_gnt, d_gnt}), 32'd0);
        chk("rst_dones", 32'({if_done, d_done}), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_d_rdata", 32'(d_rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        next_cycle();
        rst = 1'b0; do_preload = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Write 0xFFFF to 0x0005, then read it back.
        access(1'b1, 1'b0, 16'h0005, 16'hFFFF);
        access(1'b1, 1'b1, 16'h0005, 16'h0000);

        // Simultaneous requests, twice.
        tie(16'h0000, 16'h0001);
        tie(16'h0002, 16'h0003);

        // Streaming instruction fetches from 0..19.
        next_cycle();
        if_req = 1'b1; if_addr = '0;
        last_g = 0;
        for (int k = 0; k < 20; k++) begin
            got = 1'b0;
            for (int n = 0; n < 10; n++) begin
                @(negedge clk);
                if (if_gnt === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                next_cycle();
            end
            chk("stream_gnt", 32'(got), 32'd1);
            if (k > 0) chk("stream_gap", 32'(cyc - last_g), 32'd5);
            last_g = cyc;
            push_exp(1'b0, 1'b1, AW'(k), '0);
            next_cycle();
            if (k == 19) if_req = 1'b0; else if_addr = AW'(k + 1);
        end
        repeat (6) next_cycle();
        @(negedge clk);
        chk("stream_drained", 32'(exp_if.size()), 32'd0);

        // Reset during WAIT aborts the access with no done.
        next_cycle();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h0007;
        @(negedge clk);
        chk("abort_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        d_req = 1'b0;
        @(negedge clk);
        chk("abort_issue_cs", 32'(mem_cs), 32'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wait_busy", 32'(busy), 32'd1);
        next_cycle();
        rst = 1'b0;
        last_if = '0; last_d = '0; favour_if = 1'b0;
        @(negedge clk);
        chk("abort_mem_cs", 32'(mem_cs), 32'd0);
        chk("abort_mem_wen", 32'(mem_wen), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_d_rdata", 32'(d_rdata), 32'd0);
        for (int k = 0; k < 6; k++) begin
            next_cycle();
            @(negedge clk);
            chk("abort_no_done", 32'(d_done), 32'd0);
        end
        access(1'b1, 1'b1, 16'h0007, 16'h0000);

        // Data request raised while an instruction fetch is in flight.
        next_cycle();
        if_req = 1'b1; if_addr = 16'h0009;
        @(negedge clk);
        chk("hold_if_gnt", 32'(if_gnt), 32'd1);
        push_exp(1'b0, 1'b1, 16'h0009, '0);
        next_cycle();
        if_req = 1'b0;
        @(negedge clk);
        next_cycle();
        d_req = 1'b1; d_wen = 1'b1; d_addr = 16'h000A;
        @(negedge clk);
        chk("hold_no_gnt", 32'(d_gnt), 32'd0);
        for (int k = 3; k <= 4; k++) begin
            next_cycle();
            @(negedge clk);
            chk("hold_no_gnt", 32'(d_gnt), 32'd0);
        end
        next_cycle();
        @(negedge clk);
        chk("hold_gnt_at_done", 32'(d_gnt), 32'd1);
        chk("hold_if_done", 32'(if_done), 32'd1);
        push_exp(1'b1, 1'b1, 16'h000A, '0);
        next_cycle();
        d_req = 1'b0;
        repeat (4) next_cycle();
        @(negedge clk);
        chk("hold_d_done", 32'(d_done), 32'd1);

        repeat (3) next_cycle();
        @(negedge clk);
        chk("sb_if_empty", 32'(exp_if.size()), 32'd0);
        chk("sb_d_empty", 32'(exp_d.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
